// File: rtl/pos_onehot_pkg.sv
// Shared types and helpers for the position-to-one-hot sequencer.
package pos_onehot_pkg;

  localparam int POS_W    = 3;
  localparam int ONEHOT_W = 8;

  typedef enum logic {
    IDLE,
    DRIVE
  } state_e;

  function automatic logic [ONEHOT_W-1:0] pos2onehot(input logic [POS_W-1:0] pos);
    return ONEHOT_W'(1) << pos;
  endfunction

endpackage

// File: rtl/pos_onehot_fifo.sv
// Small FIFO of position codes with wrap-bit pointers.
// POS_ONEHOT_OCC_EN adds a registered occupancy output.
module pos_onehot_fifo
  import pos_onehot_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [POS_W-1:0]         din,
  output logic [POS_W-1:0]         dout,
  output logic                     full,
  output logic                     empty
`ifdef POS_ONEHOT_OCC_EN
  ,
  output logic [$clog2(DEPTH):0]   occ
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [POS_W-1:0] mem_q [DEPTH];
  logic [POS_W-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Equal index with differing wrap bits means every slot is occupied.
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty   = (wptr_q == rptr_q);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) begin
      mem_d[wptr_q[AW-1:0]] = din;
      wptr_d = wptr_q + (AW+1)'(1);
    end
    if (do_pop) begin
      rptr_d = rptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      mem_q  <= mem_d;
    end
  end

`ifdef POS_ONEHOT_OCC_EN
  logic [AW:0] occ_q, occ_d;

  always_comb begin
    occ_d = occ_q;
    case ({do_push, do_pop})
      2'b10:   occ_d = occ_q + (AW+1)'(1);
      2'b01:   occ_d = occ_q - (AW+1)'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occ = occ_q;
`endif

endmodule

// File: rtl/pos_onehot_sequencer.sv
// Replays buffered 3-bit position codes as one-hot vectors held for hold+1 cycles.
// POS_ONEHOT_OCC_EN exposes the FIFO occupancy on port occ.
module pos_onehot_sequencer
  import pos_onehot_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int HOLD_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [POS_W-1:0]         in_pos,
  input  logic [HOLD_W-1:0]        hold,
  output logic [ONEHOT_W-1:0]      out_onehot,
  output logic                     out_valid,
  output logic                     done
`ifdef POS_ONEHOT_OCC_EN
  ,
  output logic [$clog2(DEPTH):0]   occ
`endif
);

  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_pop;
  logic                push;
  logic                load;
  logic [POS_W-1:0]    head;

  state_e              state_q, state_d;
  logic [HOLD_W-1:0]   cnt_q, cnt_d;
  logic [ONEHOT_W-1:0] onehot_q, onehot_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;

  assign in_ready = ~fifo_full & rst_n;
  assign push     = in_valid & in_ready;

  pos_onehot_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (fifo_pop),
    .din   (in_pos),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
`ifdef POS_ONEHOT_OCC_EN
    ,
    .occ   (occ)
`endif
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    onehot_d = onehot_q;
    valid_d  = valid_q;
    load     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) load = 1'b1;
      end
      DRIVE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - HOLD_W'(1);
        end else if (!fifo_empty) begin
          load = 1'b1;
        end else begin
          state_d  = IDLE;
          onehot_d = '0;
          valid_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      state_d  = DRIVE;
      onehot_d = pos2onehot(head);
      cnt_d    = hold;
      valid_d  = 1'b1;
    end
    fifo_pop = load;
    // done is registered, so flag the upcoming cycle that will be the last of its code.
    done_d = (state_d == DRIVE) && (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      onehot_q <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      onehot_q <= onehot_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

  assign out_onehot = onehot_q;
  assign out_valid  = valid_q;
  assign done       = done_q;

endmodule
